// File: rtl/regfile_write_arbiter_if.sv
// Requester and register-file write-port bundle for regfile_write_arbiter.
// The master side drives requests and clear commands; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      clr_start;
    logic                      clr_busy;
    logic                      clr_done;
    logic                      rf_wr_en;
    logic [ADDR_W-1:0]         rf_wr_addr;
    logic [DATA_W-1:0]         rf_wr_data;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, clr_done,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, clr_done,
        output rf_wr_en, rf_wr_addr, rf_wr_data, grant_id
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// sequencer that zero-fills every register when clr_start is pulsed.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ID_W-1:0]   grant_q;
    logic              busy_q;
    logic              done_q;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] ready;
    int                idx;

    // Search upward from rr_ptr, wrapping at NUM_REQ rather than a power of two.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.req_valid[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    // A clear command in the same cycle beats any pending request.
    always_comb begin
        ready = '0;
        if (state == ST_ARB && !bus.clr_start && win_found)
            ready[win_idx] = 1'b1;
    end

    assign bus.req_ready  = ready;
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_wr_data = wr_data_q;
    assign bus.grant_id   = grant_q;
    assign bus.clr_busy   = busy_q;
    assign bus.clr_done   = done_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            cnt       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                ST_ARB: begin
                    done_q <= 1'b0;
                    if (bus.clr_start) begin
                        state   <= ST_CLEAR;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        wr_en_q <= 1'b0;
                    end else if (win_found) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        wr_data_q <= bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
                        grant_q   <= win_idx;
                        rr_ptr    <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    end else begin
                        wr_en_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt;
                    wr_data_q <= '0;
                    grant_q   <= '0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= ST_ARB;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end
endmodule
